// File: rtl/jpeg_byte_serializer.sv
// Purpose: turns variable-length 128-bit encoder words into one image-buffer byte write per cycle.
// Latency: first byte is written the cycle after a word is accepted; an n-byte word takes n write cycles.
// Backpressure: ready_out drops while a word is held and returns one cycle after its last byte.
module jpeg_byte_serializer #(
    parameter int BUFFER_BYTES = 40000
) (
    input  logic         clock_in,
    input  logic         reset_n_in,
    input  logic         start_capture_in,
    input  logic [127:0] data_in,
    input  logic [4:0]   bytes_valid_in,
    input  logic         data_valid_in,
    input  logic         image_valid_in,
    output logic         ready_out,
    output logic [15:0]  write_address_out,
    output logic [7:0]   write_data_out,
    output logic         write_enable_out,
    output logic [15:0]  bytes_available_out,
    output logic         capture_done_out,
    output logic         overflow_out
);

    // Write addresses run 0..BUFFER_BYTES-1; the counter itself may reach BUFFER_BYTES.
    localparam logic [15:0] BUF_LIMIT = BUFFER_BYTES[15:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t         state_q;
    logic           start_prev_q;
    logic           ready_q;
    logic           busy_q;       // holding register occupied (including the gap cycle)
    logic [4:0]     left_q;       // bytes still to write after the current one
    logic [127:0]   hold_q;       // remaining bytes, next byte always in [127:120]
    logic           end_pend_q;
    logic [15:0]    addr_q;
    logic [15:0]    avail_q;
    logic           overflow_q;
    logic           done_q;
    logic           we_q;
    logic [15:0]    waddr_q;
    logic [7:0]     wdata_q;

    logic           start_edge;
    logic [4:0]     n_clamp;
    logic           accept;
    logic           consume;
    logic [7:0]     cur_byte;
    logic           has_room;

    // Decode this cycle's events: start edge, word acceptance and byte consumption.
    always_comb begin
        start_edge = start_capture_in & ~start_prev_q;
        n_clamp    = (bytes_valid_in > 5'd16) ? 5'd16 : bytes_valid_in;
        accept     = (state_q == ST_ACTIVE) && ready_q && data_valid_in &&
                     (n_clamp != 5'd0) && !start_edge;
        consume    = accept || (busy_q && (left_q != 5'd0) && !start_edge);
        cur_byte   = accept ? data_in[127:120] : hold_q[127:120];
        has_room   = addr_q < BUF_LIMIT;
    end

    // Capture FSM: start handling, serialisation, buffer-full dropping and end-of-image.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            left_q       <= 5'd0;
            hold_q       <= '0;
            end_pend_q   <= 1'b0;
            addr_q       <= 16'd0;
            avail_q      <= 16'd0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= 16'd0;
            wdata_q      <= 8'd0;
        end else begin
            start_prev_q <= start_capture_in;
            we_q         <= 1'b0;
            if (start_edge) begin
                // A start edge discards any partial word and restarts at address 0.
                state_q    <= ST_ACTIVE;
                ready_q    <= 1'b1;
                busy_q     <= 1'b0;
                left_q     <= 5'd0;
                hold_q     <= '0;
                end_pend_q <= 1'b0;
                addr_q     <= 16'd0;
                avail_q    <= 16'd0;
                overflow_q <= 1'b0;
                done_q     <= 1'b0;
                waddr_q    <= 16'd0;
                wdata_q    <= 8'd0;
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (consume) begin
                            if (has_room) begin
                                we_q    <= 1'b1;
                                waddr_q <= addr_q;
                                wdata_q <= cur_byte;
                                addr_q  <= addr_q + 16'd1;
                                avail_q <= addr_q + 16'd1;
                            end else begin
                                // Buffer full: the byte still costs a cycle but is dropped.
                                overflow_q <= 1'b1;
                            end
                        end
                        if (accept) begin
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            left_q  <= n_clamp - 5'd1;
                            hold_q  <= {data_in[119:0], 8'h00};
                            if (image_valid_in) begin
                                end_pend_q <= 1'b1;
                            end
                        end else if (busy_q) begin
                            if (left_q != 5'd0) begin
                                left_q <= left_q - 5'd1;
                                hold_q <= {hold_q[119:0], 8'h00};
                                if (image_valid_in) begin
                                    end_pend_q <= 1'b1;
                                end
                            end else begin
                                // Gap cycle after the last byte: finish the image or reopen.
                                busy_q <= 1'b0;
                                hold_q <= '0;
                                if (end_pend_q || image_valid_in) begin
                                    state_q    <= ST_DONE;
                                    done_q     <= 1'b1;
                                    end_pend_q <= 1'b0;
                                end else begin
                                    ready_q <= 1'b1;
                                end
                            end
                        end else if (image_valid_in) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready_out           = ready_q;
    assign write_address_out   = waddr_q;
    assign write_data_out      = wdata_q;
    assign write_enable_out    = we_q;
    assign bytes_available_out = avail_q;
    assign capture_done_out    = done_q;
    assign overflow_out        = overflow_q;

endmodule

// File: tb/tb_jpeg_byte_serializer.sv
// Directed bench for jpeg_byte_serializer with a 20-byte buffer so the full-buffer path is reachable.
// Writes are logged at the falling edge; checks compare the log and outputs to hand-computed values.
// Inputs change 1 time unit after the rising edge or after the falling edge, never on the rising edge.
module tb_jpeg_byte_serializer;

    logic         clock_in = 1'b0;
    logic         reset_n_in = 1'b0;
    logic         start_capture_in = 1'b0;
    logic [127:0] data_in = '0;
    logic [4:0]   bytes_valid_in = 5'd0;
    logic         data_valid_in = 1'b0;
    logic         image_valid_in = 1'b0;
    logic         ready_out;
    logic [15:0]  write_address_out;
    logic [7:0]   write_data_out;
    logic         write_enable_out;
    logic [15:0]  bytes_available_out;
    logic         capture_done_out;
    logic         overflow_out;

    jpeg_byte_serializer #(.BUFFER_BYTES(20)) dut (
        .clock_in            (clock_in),
        .reset_n_in          (reset_n_in),
        .start_capture_in    (start_capture_in),
        .data_in             (data_in),
        .bytes_valid_in      (bytes_valid_in),
        .data_valid_in       (data_valid_in),
        .image_valid_in      (image_valid_in),
        .ready_out           (ready_out),
        .write_address_out   (write_address_out),
        .write_data_out      (write_data_out),
        .write_enable_out    (write_enable_out),
        .bytes_available_out (bytes_available_out),
        .capture_done_out    (capture_done_out),
        .overflow_out        (overflow_out)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    logic [15:0] log_addr [256];
    logic [7:0]  log_dat  [256];
    int          log_cyc  [256];
    int          wr_n = 0;
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;

    // Write logger and capture_done rising-edge timestamp.
    always @(negedge clock_in) begin
        if (write_enable_out && wr_n < 256) begin
            log_addr[wr_n] = write_address_out;
            log_dat[wr_n]  = write_data_out;
            log_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
        if (capture_done_out && !done_prev) done_rise_cyc = cyc;
        done_prev = capture_done_out;
    end

    int compared = 0;
    int mismatched = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clock_in);
        #1;
    endtask

    task automatic pulse_start();
        start_capture_in = 1'b1;
        tick();
        start_capture_in = 1'b0;
    endtask

    // Returns at falling edge +1 with ready_out high; rc is the cycle number seen.
    task automatic wait_ready(output int rc);
        int n;
        n = 0;
        sample();
        while (!ready_out && n < 200) begin
            n++;
            sample();
        end
        if (!ready_out) chk("ready_timeout", 32'(ready_out), 32'd1);
        rc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        sample();
        while (!capture_done_out && n < 200) begin
            n++;
            sample();
        end
        if (!capture_done_out) chk("done_timeout", 32'(capture_done_out), 32'd1);
    endtask

    task automatic send_word(input logic [127:0] d, input logic [4:0] bv, output int drv_cyc);
        int rc;
        wait_ready(rc);
        data_in        = d;
        bytes_valid_in = bv;
        data_valid_in  = 1'b1;
        drv_cyc        = cyc;
        tick();
        data_valid_in  = 1'b0;
    endtask

    task automatic pulse_image_valid();
        image_valid_in = 1'b1;
        tick();
        image_valid_in = 1'b0;
    endtask

    task automatic check_log(input string tag, input int base);
        chk({tag, "_count"}, 32'(wr_n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wr_n) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[base + i]), 32'(i));
                chk($sformatf("%s_data%0d", tag, i), 32'(log_dat[base + i]), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(ready_out), 32'd0);
        chk({tag, "_we"},    32'(write_enable_out), 32'd0);
        chk({tag, "_addr"},  32'(write_address_out), 32'd0);
        chk({tag, "_data"},  32'(write_data_out), 32'd0);
        chk({tag, "_avail"}, 32'(bytes_available_out), 32'd0);
        chk({tag, "_done"},  32'(capture_done_out), 32'd0);
        chk({tag, "_ovf"},   32'(overflow_out), 32'd0);
    endtask

    initial begin
        int base;
        int base2;
        int drv;
        int drv2;
        int rc;
        int lowcnt;

        // Reset state.
        sample();
        sample();
        check_all_zero("rst");
        #2 reset_n_in = 1'b1;
        tick();

        // 1: one 16-byte word, image_valid one cycle later.
        pulse_start();
        sample();
        chk("t1_ready_after_start", 32'(ready_out), 32'd1);
        base = wr_n;
        send_word(128'h0102030405060708090A0B0C0D0E0F10, 5'd16, drv);
        image_valid_in = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 16; i++) begin
            sample();
            if (!ready_out && write_enable_out) lowcnt++;
            if (i == 0) begin
                @(posedge clock_in);
                #1;
                image_valid_in = 1'b0;
            end
        end
        sample();
        chk("t1_ready_low_writes", 32'(lowcnt), 32'd16);
        chk("t1_done", 32'(capture_done_out), 32'd1);
        chk("t1_we_after", 32'(write_enable_out), 32'd0);
        chk("t1_ready_done", 32'(ready_out), 32'd0);
        chk("t1_avail", 32'(bytes_available_out), 32'd16);
        chk("t1_ovf", 32'(overflow_out), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
        check_log("t1", base);
        chk("t1_first_write_cyc", 32'(log_cyc[base]), 32'(drv + 1));
        chk("t1_done_cyc", 32'(done_rise_cyc), 32'(log_cyc[wr_n - 1] + 1));

        // Words are ignored while DONE.
        base = wr_n;
        data_valid_in  = 1'b1;
        bytes_valid_in = 5'd4;
        tick();
        tick();
        data_valid_in  = 1'b0;
        sample();
        chk("done_ignore_writes", 32'(wr_n - base), 32'd0);
        chk("done_held", 32'(capture_done_out), 32'd1);

        // 2: 3, 1, 0 and clamped 16-byte words fill the buffer exactly.
        pulse_start();
        sample();
        chk("t2_done_cleared", 32'(capture_done_out), 32'd0);
        chk("t2_avail_cleared", 32'(bytes_available_out), 32'd0);
        base = wr_n;
        send_word({24'hA1A2A3, {13{8'hEE}}}, 5'd3, drv);
        send_word({8'hB1, {15{8'h55}}}, 5'd1, drv);
        wait_ready(rc);
        data_in        = {16{8'h99}};
        bytes_valid_in = 5'd0;
        data_valid_in  = 1'b1;
        tick();
        data_valid_in  = 1'b0;
        sample();
        chk("t2_zero_ready", 32'(ready_out), 32'd1);
        chk("t2_zero_nowrite", 32'(wr_n - base), 32'd4);
        send_word(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 5'd20, drv);
        wait_ready(rc);
        chk("t2_clamp_ready_cyc", 32'(rc - drv), 32'd17);
        pulse_image_valid();
        sample();
        chk("t2_done", 32'(capture_done_out), 32'd1);
        chk("t2_avail", 32'(bytes_available_out), 32'd20);
        chk("t2_ovf_exact_full", 32'(overflow_out), 32'd0);
        exp_q.delete();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hB1);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hC0 + i));
        check_log("t2", base);

        // 3: two 16-byte words overflow the 20-byte buffer.
        pulse_start();
        base = wr_n;
        send_word(128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF, 5'd16, drv);
        wait_ready(rc);
        chk("t3_w1_ready_cyc", 32'(rc - drv), 32'd17);
        chk("t3_w1_ovf", 32'(overflow_out), 32'd0);
        chk("t3_w1_avail", 32'(bytes_available_out), 32'd16);
        send_word(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 5'd16, drv2);
        wait_ready(rc);
        chk("t3_w2_ready_cyc", 32'(rc - drv2), 32'd17);
        chk("t3_ovf", 32'(overflow_out), 32'd1);
        chk("t3_avail", 32'(bytes_available_out), 32'd20);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hD0 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hE0 + i));
        check_log("t3", base);
        pulse_image_valid();
        sample();
        chk("t3_done", 32'(capture_done_out), 32'd1);
        chk("t3_ovf_held", 32'(overflow_out), 32'd1);

        // 4: image_valid during a 5-byte word.
        pulse_start();
        sample();
        chk("t4_ovf_cleared", 32'(overflow_out), 32'd0);
        base = wr_n;
        send_word({40'hF1F2F3F4F5, {11{8'h00}}}, 5'd5, drv);
        pulse_image_valid();
        wait_done();
        chk("t4_writes", 32'(wr_n - base), 32'd5);
        chk("t4_done_cyc", 32'(done_rise_cyc), 32'(log_cyc[wr_n - 1] + 1));
        chk("t4_avail", 32'(bytes_available_out), 32'd5);

        // 5: start edge while the 4th of 10 bytes would be written.
        pulse_start();
        base = wr_n;
        send_word({80'h1112131415161718191A, {6{8'h00}}}, 5'd10, drv);
        tick();
        tick();
        pulse_start();
        sample();
        chk("t5_we_at_restart", 32'(write_enable_out), 32'd0);
        chk("t5_avail_restart", 32'(bytes_available_out), 32'd0);
        chk("t5_addr_restart", 32'(write_address_out), 32'd0);
        chk("t5_ready_restart", 32'(ready_out), 32'd1);
        sample();
        sample();
        exp_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        check_log("t5a", base);
        base2 = wr_n;
        send_word({16'h7788, {14{8'h00}}}, 5'd2, drv);
        pulse_image_valid();
        wait_done();
        exp_q.delete();
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        check_log("t5b", base2);
        chk("t5_avail", 32'(bytes_available_out), 32'd2);

        // 6: asynchronous reset mid-word, then IDLE ignores words.
        pulse_start();
        send_word({16{8'h3C}}, 5'd16, drv);
        tick();
        tick();
        #2 reset_n_in = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clock_in);
        #1 reset_n_in = 1'b1;
        base = wr_n;
        data_in        = {16{8'h5A}};
        bytes_valid_in = 5'd4;
        data_valid_in  = 1'b1;
        tick();
        tick();
        tick();
        data_valid_in  = 1'b0;
        sample();
        chk("t6_idle_nowrite", 32'(wr_n - base), 32'd0);
        chk("t6_idle_ready", 32'(ready_out), 32'd0);
        chk("t6_idle_done", 32'(capture_done_out), 32'd0);
        pulse_start();
        sample();
        chk("t6_ready_after_start", 32'(ready_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
